// File: rtl/aes_pkg.sv
// Shared types, constants and round-function helpers for the AES-128 key schedule.
package aes_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned NUM_SLOTS  = NUM_ROUNDS + 1;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  // Word 0 sits in the most significant position, matching KEY byte order.
  typedef struct packed {
    word_t w0;
    word_t w1;
    word_t w2;
    word_t w3;
  } round_key_t;

  // Indexed directly by the round counter; entry 0 and 11..15 are never used.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // sub_rot is SubWord(RotWord(w3)) of the previous round key.
  function automatic round_key_t next_round_key(input round_key_t prev,
                                                input word_t      sub_rot,
                                                input logic [7:0] rc);
    round_key_t nk;
    nk.w0 = prev.w0 ^ sub_rot ^ {rc, 24'h0};
    nk.w1 = prev.w1 ^ nk.w0;
    nk.w2 = prev.w2 ^ nk.w1;
    nk.w3 = prev.w3 ^ nk.w2;
    return nk;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] sub_byte_c
);

  always_comb begin
    sub_byte_c = 8'h00;
    case (in_byte)
      8'h00: sub_byte_c = 8'h63; 8'h01: sub_byte_c = 8'h7c; 8'h02: sub_byte_c = 8'h77; 8'h03: sub_byte_c = 8'h7b;
      8'h04: sub_byte_c = 8'hf2; 8'h05: sub_byte_c = 8'h6b; 8'h06: sub_byte_c = 8'h6f; 8'h07: sub_byte_c = 8'hc5;
      8'h08: sub_byte_c = 8'h30; 8'h09: sub_byte_c = 8'h01; 8'h0a: sub_byte_c = 8'h67; 8'h0b: sub_byte_c = 8'h2b;
      8'h0c: sub_byte_c = 8'hfe; 8'h0d: sub_byte_c = 8'hd7; 8'h0e: sub_byte_c = 8'hab; 8'h0f: sub_byte_c = 8'h76;
      8'h10: sub_byte_c = 8'hca; 8'h11: sub_byte_c = 8'h82; 8'h12: sub_byte_c = 8'hc9; 8'h13: sub_byte_c = 8'h7d;
      8'h14: sub_byte_c = 8'hfa; 8'h15: sub_byte_c = 8'h59; 8'h16: sub_byte_c = 8'h47; 8'h17: sub_byte_c = 8'hf0;
      8'h18: sub_byte_c = 8'had; 8'h19: sub_byte_c = 8'hd4; 8'h1a: sub_byte_c = 8'ha2; 8'h1b: sub_byte_c = 8'haf;
      8'h1c: sub_byte_c = 8'h9c; 8'h1d: sub_byte_c = 8'ha4; 8'h1e: sub_byte_c = 8'h72; 8'h1f: sub_byte_c = 8'hc0;
      8'h20: sub_byte_c = 8'hb7; 8'h21: sub_byte_c = 8'hfd; 8'h22: sub_byte_c = 8'h93; 8'h23: sub_byte_c = 8'h26;
      8'h24: sub_byte_c = 8'h36; 8'h25: sub_byte_c = 8'h3f; 8'h26: sub_byte_c = 8'hf7; 8'h27: sub_byte_c = 8'hcc;
      8'h28: sub_byte_c = 8'h34; 8'h29: sub_byte_c = 8'ha5; 8'h2a: sub_byte_c = 8'he5; 8'h2b: sub_byte_c = 8'hf1;
      8'h2c: sub_byte_c = 8'h71; 8'h2d: sub_byte_c = 8'hd8; 8'h2e: sub_byte_c = 8'h31; 8'h2f: sub_byte_c = 8'h15;
      8'h30: sub_byte_c = 8'h04; 8'h31: sub_byte_c = 8'hc7; 8'h32: sub_byte_c = 8'h23; 8'h33: sub_byte_c = 8'hc3;
      8'h34: sub_byte_c = 8'h18; 8'h35: sub_byte_c = 8'h96; 8'h36: sub_byte_c = 8'h05; 8'h37: sub_byte_c = 8'h9a;
      8'h38: sub_byte_c = 8'h07; 8'h39: sub_byte_c = 8'h12; 8'h3a: sub_byte_c = 8'h80; 8'h3b: sub_byte_c = 8'he2;
      8'h3c: sub_byte_c = 8'heb; 8'h3d: sub_byte_c = 8'h27; 8'h3e: sub_byte_c = 8'hb2; 8'h3f: sub_byte_c = 8'h75;
      8'h40: sub_byte_c = 8'h09; 8'h41: sub_byte_c = 8'h83; 8'h42: sub_byte_c = 8'h2c; 8'h43: sub_byte_c = 8'h1a;
      8'h44: sub_byte_c = 8'h1b; 8'h45: sub_byte_c = 8'h6e; 8'h46: sub_byte_c = 8'h5a; 8'h47: sub_byte_c = 8'ha0;
      8'h48: sub_byte_c = 8'h52; 8'h49: sub_byte_c = 8'h3b; 8'h4a: sub_byte_c = 8'hd6; 8'h4b: sub_byte_c = 8'hb3;
      8'h4c: sub_byte_c = 8'h29; 8'h4d: sub_byte_c = 8'he3; 8'h4e: sub_byte_c = 8'h2f; 8'h4f: sub_byte_c = 8'h84;
      8'h50: sub_byte_c = 8'h53; 8'h51: sub_byte_c = 8'hd1; 8'h52: sub_byte_c = 8'h00; 8'h53: sub_byte_c = 8'hed;
      8'h54: sub_byte_c = 8'h20; 8'h55: sub_byte_c = 8'hfc; 8'h56: sub_byte_c = 8'hb1; 8'h57: sub_byte_c = 8'h5b;
      8'h58: sub_byte_c = 8'h6a; 8'h59: sub_byte_c = 8'hcb; 8'h5a: sub_byte_c = 8'hbe; 8'h5b: sub_byte_c = 8'h39;
      8'h5c: sub_byte_c = 8'h4a; 8'h5d: sub_byte_c = 8'h4c; 8'h5e: sub_byte_c = 8'h58; 8'h5f: sub_byte_c = 8'hcf;
      8'h60: sub_byte_c = 8'hd0; 8'h61: sub_byte_c = 8'hef; 8'h62: sub_byte_c = 8'haa; 8'h63: sub_byte_c = 8'hfb;
      8'h64: sub_byte_c = 8'h43; 8'h65: sub_byte_c = 8'h4d; 8'h66: sub_byte_c = 8'h33; 8'h67: sub_byte_c = 8'h85;
      8'h68: sub_byte_c = 8'h45; 8'h69: sub_byte_c = 8'hf9; 8'h6a: sub_byte_c = 8'h02; 8'h6b: sub_byte_c = 8'h7f;
      8'h6c: sub_byte_c = 8'h50; 8'h6d: sub_byte_c = 8'h3c; 8'h6e: sub_byte_c = 8'h9f; 8'h6f: sub_byte_c = 8'ha8;
      8'h70: sub_byte_c = 8'h51; 8'h71: sub_byte_c = 8'ha3; 8'h72: sub_byte_c = 8'h40; 8'h73: sub_byte_c = 8'h8f;
      8'h74: sub_byte_c = 8'h92; 8'h75: sub_byte_c = 8'h9d; 8'h76: sub_byte_c = 8'h38; 8'h77: sub_byte_c = 8'hf5;
      8'h78: sub_byte_c = 8'hbc; 8'h79: sub_byte_c = 8'hb6; 8'h7a: sub_byte_c = 8'hda; 8'h7b: sub_byte_c = 8'h21;
      8'h7c: sub_byte_c = 8'h10; 8'h7d: sub_byte_c = 8'hff; 8'h7e: sub_byte_c = 8'hf3; 8'h7f: sub_byte_c = 8'hd2;
      8'h80: sub_byte_c = 8'hcd; 8'h81: sub_byte_c = 8'h0c; 8'h82: sub_byte_c = 8'h13; 8'h83: sub_byte_c = 8'hec;
      8'h84: sub_byte_c = 8'h5f; 8'h85: sub_byte_c = 8'h97; 8'h86: sub_byte_c = 8'h44; 8'h87: sub_byte_c = 8'h17;
      8'h88: sub_byte_c = 8'hc4; 8'h89: sub_byte_c = 8'ha7; 8'h8a: sub_byte_c = 8'h7e; 8'h8b: sub_byte_c = 8'h3d;
      8'h8c: sub_byte_c = 8'h64; 8'h8d: sub_byte_c = 8'h5d; 8'h8e: sub_byte_c = 8'h19; 8'h8f: sub_byte_c = 8'h73;
      8'h90: sub_byte_c = 8'h60; 8'h91: sub_byte_c = 8'h81; 8'h92: sub_byte_c = 8'h4f; 8'h93: sub_byte_c = 8'hdc;
      8'h94: sub_byte_c = 8'h22; 8'h95: sub_byte_c = 8'h2a; 8'h96: sub_byte_c = 8'h90; 8'h97: sub_byte_c = 8'h88;
      8'h98: sub_byte_c = 8'h46; 8'h99: sub_byte_c = 8'hee; 8'h9a: sub_byte_c = 8'hb8; 8'h9b: sub_byte_c = 8'h14;
      8'h9c: sub_byte_c = 8'hde; 8'h9d: sub_byte_c = 8'h5e; 8'h9e: sub_byte_c = 8'h0b; 8'h9f: sub_byte_c = 8'hdb;
      8'ha0: sub_byte_c = 8'he0; 8'ha1: sub_byte_c = 8'h32; 8'ha2: sub_byte_c = 8'h3a; 8'ha3: sub_byte_c = 8'h0a;
      8'ha4: sub_byte_c = 8'h49; 8'ha5: sub_byte_c = 8'h06; 8'ha6: sub_byte_c = 8'h24; 8'ha7: sub_byte_c = 8'h5c;
      8'ha8: sub_byte_c = 8'hc2; 8'ha9: sub_byte_c = 8'hd3; 8'haa: sub_byte_c = 8'hac; 8'hab: sub_byte_c = 8'h62;
      8'hac: sub_byte_c = 8'h91; 8'had: sub_byte_c = 8'h95; 8'hae: sub_byte_c = 8'he4; 8'haf: sub_byte_c = 8'h79;
      8'hb0: sub_byte_c = 8'he7; 8'hb1: sub_byte_c = 8'hc8; 8'hb2: sub_byte_c = 8'h37; 8'hb3: sub_byte_c = 8'h6d;
      8'hb4: sub_byte_c = 8'h8d; 8'hb5: sub_byte_c = 8'hd5; 8'hb6: sub_byte_c = 8'h4e; 8'hb7: sub_byte_c = 8'ha9;
      8'hb8: sub_byte_c = 8'h6c; 8'hb9: sub_byte_c = 8'h56; 8'hba: sub_byte_c = 8'hf4; 8'hbb: sub_byte_c = 8'hea;
      8'hbc: sub_byte_c = 8'h65; 8'hbd: sub_byte_c = 8'h7a; 8'hbe: sub_byte_c = 8'hae; 8'hbf: sub_byte_c = 8'h08;
      8'hc0: sub_byte_c = 8'hba; 8'hc1: sub_byte_c = 8'h78; 8'hc2: sub_byte_c = 8'h25; 8'hc3: sub_byte_c = 8'h2e;
      8'hc4: sub_byte_c = 8'h1c; 8'hc5: sub_byte_c = 8'ha6; 8'hc6: sub_byte_c = 8'hb4; 8'hc7: sub_byte_c = 8'hc6;
      8'hc8: sub_byte_c = 8'he8; 8'hc9: sub_byte_c = 8'hdd; 8'hca: sub_byte_c = 8'h74; 8'hcb: sub_byte_c = 8'h1f;
      8'hcc: sub_byte_c = 8'h4b; 8'hcd: sub_byte_c = 8'hbd; 8'hce: sub_byte_c = 8'h8b; 8'hcf: sub_byte_c = 8'h8a;
      8'hd0: sub_byte_c = 8'h70; 8'hd1: sub_byte_c = 8'h3e; 8'hd2: sub_byte_c = 8'hb5; 8'hd3: sub_byte_c = 8'h66;
      8'hd4: sub_byte_c = 8'h48; 8'hd5: sub_byte_c = 8'h03; 8'hd6: sub_byte_c = 8'hf6; 8'hd7: sub_byte_c = 8'h0e;
      8'hd8: sub_byte_c = 8'h61; 8'hd9: sub_byte_c = 8'h35; 8'hda: sub_byte_c = 8'h57; 8'hdb: sub_byte_c = 8'hb9;
      8'hdc: sub_byte_c = 8'h86; 8'hdd: sub_byte_c = 8'hc1; 8'hde: sub_byte_c = 8'h1d; 8'hdf: sub_byte_c = 8'h9e;
      8'he0: sub_byte_c = 8'he1; 8'he1: sub_byte_c = 8'hf8; 8'he2: sub_byte_c = 8'h98; 8'he3: sub_byte_c = 8'h11;
      8'he4: sub_byte_c = 8'h69; 8'he5: sub_byte_c = 8'hd9; 8'he6: sub_byte_c = 8'h8e; 8'he7: sub_byte_c = 8'h94;
      8'he8: sub_byte_c = 8'h9b; 8'he9: sub_byte_c = 8'h1e; 8'hea: sub_byte_c = 8'h87; 8'heb: sub_byte_c = 8'he9;
      8'hec: sub_byte_c = 8'hce; 8'hed: sub_byte_c = 8'h55; 8'hee: sub_byte_c = 8'h28; 8'hef: sub_byte_c = 8'hdf;
      8'hf0: sub_byte_c = 8'h8c; 8'hf1: sub_byte_c = 8'ha1; 8'hf2: sub_byte_c = 8'h89; 8'hf3: sub_byte_c = 8'h0d;
      8'hf4: sub_byte_c = 8'hbf; 8'hf5: sub_byte_c = 8'he6; 8'hf6: sub_byte_c = 8'h42; 8'hf7: sub_byte_c = 8'h68;
      8'hf8: sub_byte_c = 8'h41; 8'hf9: sub_byte_c = 8'h99; 8'hfa: sub_byte_c = 8'h2d; 8'hfb: sub_byte_c = 8'h0f;
      8'hfc: sub_byte_c = 8'hb0; 8'hfd: sub_byte_c = 8'h54; 8'hfe: sub_byte_c = 8'hbb; 8'hff: sub_byte_c = 8'h16;
      default: sub_byte_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per cycle into 11 flip-flop slots,
// started by a rising edge of START and read back combinationally by index.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         START,
  input  logic [127:0] KEY,
  input  logic [3:0]   RK_IDX,
  output logic [127:0] RK_DATA,
  output logic         BUSY,
  output logic         DONE
);

  state_t             state_q, state_d;
  logic               start_q;
  logic [CNT_W-1:0]   cnt_q;
  block_t             slot_q [NUM_SLOTS];
  logic               busy_q, done_q;

  logic               start_edge_c;
  logic               load_key_c;
  logic               expand_c;
  round_key_t         prev_key_c;
  round_key_t         next_key_c;
  word_t              rot_c;
  word_t              sub_word_c;

  assign start_edge_c = START & ~start_q;

  // Next-state and datapath enables.
  always_comb begin
    state_d    = state_q;
    load_key_c = 1'b0;
    expand_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          load_key_c = 1'b1;
          state_d    = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        expand_c = 1'b1;
        if (cnt_q == CNT_W'(NUM_ROUNDS)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!START) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_EXPAND);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Previous round key: slot[cnt-1].
  always_comb begin
    prev_key_c = '0;
    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
      if (cnt_q == CNT_W'(i + 1)) begin
        prev_key_c = slot_q[i];
      end
    end
  end

  assign rot_c = rot_word(prev_key_c.w3);

  for (genvar g = 0; g < 4; g++) begin : g_sub_word
    aes_sbox u_sbox (
      .in_byte    (rot_c[8*g +: 8]),
      .sub_byte_c (sub_word_c[8*g +: 8])
    );
  end

  assign next_key_c = next_round_key(prev_key_c, sub_word_c, RCON[cnt_q]);

  // Start-edge history, round counter and round-key slots.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      start_q <= 1'b0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      start_q <= START;
      if (load_key_c) begin
        slot_q[0] <= KEY;
        cnt_q     <= CNT_W'(1);
      end else if (expand_c) begin
        for (int unsigned i = 1; i < NUM_SLOTS; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            slot_q[i] <= next_key_c;
          end
        end
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Out-of-range indices read as zero.
  always_comb begin
    RK_DATA = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (RK_IDX == CNT_W'(i)) begin
        RK_DATA = slot_q[i];
      end
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: expected round keys are queued when an
// expansion is launched and compared once DONE is observed.
module tb_aes_key_schedule;

  logic         CLK;
  logic         RESET_N;
  logic         START;
  logic [127:0] KEY;
  logic [3:0]   RK_IDX;
  logic [127:0] RK_DATA;
  logic         BUSY;
  logic         DONE;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        tag;
    logic [3:0]   idx;
    logic [127:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K3     = 128'hdeadbeef0123456789abcdeffedcba98;

  aes_key_schedule dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .KEY     (KEY),
    .RK_IDX  (RK_IDX),
    .RK_DATA (RK_DATA),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.idx = idx;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      RK_IDX = e.idx;
      #1;
      check(e.tag, RK_DATA, e.exp);
    end
  endtask

  // Counts edges, including the one that samples the start edge, until DONE.
  task automatic run_until_done(output int edges, output logic busy_first);
    edges = 0;
    busy_first = 1'b0;
    while (edges < 40) begin
      step();
      edges++;
      if (edges == 1) busy_first = BUSY;
      if (DONE) break;
    end
  endtask

  initial begin
    int   n;
    logic bf;
    logic flag;

    RESET_N = 1'b0;
    START   = 1'b0;
    KEY     = '0;
    RK_IDX  = 4'd0;

    #3;
    check("rst_busy", 128'(BUSY), 128'(0));
    check("rst_done", 128'(DONE), 128'(0));
    check("rst_rk0", RK_DATA, '0);
    RK_IDX = 4'd10;
    #1;
    check("rst_rk10", RK_DATA, '0);
    repeat (2) step();
    RESET_N = 1'b1;
    step();
    check("idle_busy", 128'(BUSY), 128'(0));

    // FIPS-197 key
    KEY = K1;
    push("a_rk0", 4'd0, K1);
    push("a_rk1", 4'd1, K1_R1);
    push("a_rk2", 4'd2, K1_R2);
    push("a_rk10", 4'd10, K1_R10);
    push("a_rk11", 4'd11, '0);
    push("a_rk15", 4'd15, '0);
    START = 1'b1;
    run_until_done(n, bf);
    check("a_latency", 128'(n), 128'(11));
    check("a_busy_first", 128'(bf), 128'(1));
    check("a_busy_in_done", 128'(BUSY), 128'(0));
    drain();

    // DONE holds while START stays high
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      flag &= DONE & ~BUSY;
    end
    check("done_hold", 128'(flag), 128'(1));
    START = 1'b0;
    step();
    check("done_fall", 128'(DONE), 128'(0));
    check("idle_busy_after_done", 128'(BUSY), 128'(0));
    push("keep_rk10", 4'd10, K1_R10);
    push("keep_rk1", 4'd1, K1_R1);
    drain();
    step();

    // Second key, restart overwrites all slots
    KEY = K2;
    push("b_rk0", 4'd0, K2);
    push("b_rk1", 4'd1, K2_R1);
    push("b_rk10", 4'd10, K2_R10);
    push("b_rk12", 4'd12, '0);
    START = 1'b1;
    run_until_done(n, bf);
    check("b_latency", 128'(n), 128'(11));
    drain();
    START = 1'b0;
    step();
    step();

    // START re-pulsed with a new KEY mid-expansion is ignored
    KEY = K1;
    push("c_rk0", 4'd0, K1);
    push("c_rk1", 4'd1, K1_R1);
    push("c_rk10", 4'd10, K1_R10);
    START = 1'b1;
    n = 0;
    repeat (4) begin
      step();
      n++;
    end
    START = 1'b0;
    step();
    n++;
    START = 1'b1;
    KEY = K3;
    while (!DONE && n < 40) begin
      step();
      n++;
    end
    check("c_latency", 128'(n), 128'(11));
    drain();
    START = 1'b0;
    step();
    step();

    // Reset in the middle of an expansion
    KEY = K2;
    START = 1'b1;
    repeat (5) step();
    check("d_busy_pre", 128'(BUSY), 128'(1));
    RK_IDX = 4'd0;
    #2;
    RESET_N = 1'b0;
    #1;
    check("d_busy_rst", 128'(BUSY), 128'(0));
    check("d_done_rst", 128'(DONE), 128'(0));
    check("d_rk0_rst", RK_DATA, '0);
    START = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      flag |= BUSY | DONE;
    end
    check("d_stay_idle", 128'(flag), 128'(0));
    check("d_rk0_idle", RK_DATA, '0);

    // START held high across reset release
    RESET_N = 1'b0;
    KEY = K2;
    START = 1'b1;
    step();
    RESET_N = 1'b1;
    push("e_rk10", 4'd10, K2_R10);
    push("e_rk0", 4'd0, K2);
    run_until_done(n, bf);
    check("e_latency", 128'(n), 128'(11));
    check("e_busy_first", 128'(bf), 128'(1));
    drain();
    flag = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      flag &= DONE & ~BUSY;
    end
    check("e_no_second", 128'(flag), 128'(1));
    START = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      flag |= BUSY | DONE;
    end
    check("e_idle_after", 128'(flag), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
